// File: rtl/spi_cmd_scheduler.sv
// spi_cmd_scheduler: round-robin owner of the SPI response path plus receive-side command dispatch
module spi_cmd_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ),
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] tx_req,
  output logic [NUM_REQ-1:0] tx_grant,
  output logic [IDX_W-1:0]   tx_sel,
  output logic               tx_busy,
  output logic [NUM_REQ-1:0] tx_done,
  output logic               tx_timeout,
  output logic               cmd_send,
  input  logic               cmd_done,
  input  logic               cmd_ready,
  input  logic [IDX_W-1:0]   rx_dest,
  output logic [NUM_REQ-1:0] rx_ready,
  output logic               rx_drop
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] TOP = IDX_W'(NUM_REQ - 1);
  typedef enum logic [1:0] {IDLE, START, WAIT, RELEASE} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n, pick, sel_n;
  logic [NUM_REQ-1:0] grant_n, done_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic busy_n, send_n, tmo_n, rx_ok;
  // first requester at or after the pointer; scanning backwards lets the nearest one win
  always_comb begin
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (tx_req[(int'(ptr) + i) % NUM_REQ]) pick = IDX_W'((int'(ptr) + i) % NUM_REQ);
  end
  // next-state and next registered-output values of the transmit FSM
  always_comb begin
    state_n = state;
    grant_n = tx_grant;
    sel_n   = tx_sel;
    busy_n  = tx_busy;
    ptr_n   = ptr;
    cnt_n   = cnt;
    send_n  = 1'b0;
    done_n  = '0;
    tmo_n   = 1'b0;
    case (state)
      IDLE: if (|tx_req) begin
        grant_n = NUM_REQ'(1) << pick;
        sel_n   = pick;
        busy_n  = 1'b1;
        state_n = START;
      end
      START: begin
        send_n  = 1'b1;
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: if (cmd_done || cnt == LAST) begin
        done_n  = tx_grant;
        tmo_n   = !cmd_done;
        state_n = RELEASE;
      end else cnt_n = cnt + CNT_W'(1);
      RELEASE: begin
        grant_n = '0;
        sel_n   = '0;
        busy_n  = 1'b0;
        ptr_n   = (tx_sel == TOP) ? '0 : tx_sel + IDX_W'(1);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // transmit state and registered outputs; reset abandons any send without a done pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      tx_grant   <= '0;
      tx_sel     <= '0;
      tx_busy    <= 1'b0;
      tx_done    <= '0;
      tx_timeout <= 1'b0;
      cmd_send   <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      cnt        <= cnt_n;
      tx_grant   <= grant_n;
      tx_sel     <= sel_n;
      tx_busy    <= busy_n;
      tx_done    <= done_n;
      tx_timeout <= tmo_n;
      cmd_send   <= send_n;
    end
  assign rx_ok = int'(rx_dest) < NUM_REQ;
  // receive dispatch: one-cycle pulse to the addressed handler, or a drop for out-of-range destinations
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_ready <= '0;
      rx_drop  <= 1'b0;
    end else begin
      rx_ready <= (cmd_ready && rx_ok) ? NUM_REQ'(1) << rx_dest : '0;
      rx_drop  <= cmd_ready && !rx_ok;
    end
endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// tb_spi_cmd_scheduler: directed checks of arbitration, send handshake, timeout and rx dispatch
module tb_spi_cmd_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] tx_req = '0;
  logic [3:0] tx_grant, tx_done, rx_ready;
  logic [1:0] tx_sel, rx_dest = '0;
  logic tx_busy, tx_timeout, cmd_send, cmd_done = 1'b0, cmd_ready = 1'b0, rx_drop;
  logic [2:0] g3, d3, rx_ready3;
  logic [1:0] s3;
  logic b3, t3, c3, rx_drop3;
  int vecs = 0, errs = 0;

  always #5 clk = ~clk;

  spi_cmd_scheduler #(.NUM_REQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .tx_req(tx_req), .tx_grant(tx_grant), .tx_sel(tx_sel),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_timeout(tx_timeout), .cmd_send(cmd_send),
    .cmd_done(cmd_done), .cmd_ready(cmd_ready), .rx_dest(rx_dest), .rx_ready(rx_ready),
    .rx_drop(rx_drop));

  spi_cmd_scheduler #(.NUM_REQ(3), .TIMEOUT(16)) dut3 (
    .clk(clk), .rst(rst), .tx_req(3'b000), .tx_grant(g3), .tx_sel(s3),
    .tx_busy(b3), .tx_done(d3), .tx_timeout(t3), .cmd_send(c3),
    .cmd_done(1'b0), .cmd_ready(cmd_ready), .rx_dest(rx_dest), .rx_ready(rx_ready3),
    .rx_drop(rx_drop3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic serve(input logic [3:0] exp, input int delay);
    int n = 0;
    while (!tx_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rr_grant", 32'(tx_grant), 32'(exp));
    @(negedge clk);
    chk("rr_send", 32'(cmd_send), 32'd1);
    repeat (delay) @(negedge clk);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    chk("rr_done", 32'(tx_done), 32'(exp));
    chk("rr_tmo", 32'(tx_timeout), 32'd0);
    @(negedge clk);
    chk("rr_idle", 32'(tx_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    chk("rst_grant", 32'({tx_grant, tx_sel, tx_busy, tx_done, tx_timeout, cmd_send}), 32'd0);
    chk("rst_rx", 32'({rx_ready, rx_drop}), 32'd0);
    rst = 1'b0;
    // single send, owner 2
    tx_req = 4'b0100;
    @(negedge clk);
    chk("ss_grant", 32'(tx_grant), 32'h4);
    chk("ss_sel", 32'(tx_sel), 32'd2);
    chk("ss_busy", 32'(tx_busy), 32'd1);
    chk("ss_nosend", 32'(cmd_send), 32'd0);
    @(negedge clk);
    chk("ss_send", 32'(cmd_send), 32'd1);
    @(negedge clk);
    chk("ss_send1", 32'(cmd_send), 32'd0);
    repeat (3) @(negedge clk);
    chk("ss_nodone", 32'(tx_done), 32'd0);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    tx_req = '0;
    chk("ss_done", 32'(tx_done), 32'h4);
    chk("ss_tmo", 32'(tx_timeout), 32'd0);
    @(negedge clk);
    chk("ss_busy0", 32'(tx_busy), 32'd0);
    chk("ss_grant0", 32'(tx_grant), 32'd0);
    chk("ss_done0", 32'(tx_done), 32'd0);
    // round robin with all four requesting
    do_reset();
    tx_req = 4'b1111;
    serve(4'b0001, 2);
    serve(4'b0010, 0);
    serve(4'b0100, 3);
    serve(4'b1000, 1);
    serve(4'b0001, 0);
    rst = 1'b1;
    tx_req = 4'b1001;
    @(negedge clk);
    rst = 1'b0;
    serve(4'b0001, 1);
    serve(4'b1000, 1);
    serve(4'b0001, 1);
    serve(4'b1000, 1);
    // timeout abort
    do_reset();
    tx_req = 4'b0010;
    @(negedge clk);
    chk("to_grant", 32'(tx_grant), 32'h2);
    @(negedge clk);
    chk("to_send", 32'(cmd_send), 32'd1);
    repeat (15) @(negedge clk);
    chk("to_early", 32'({tx_done, tx_timeout}), 32'd0);
    @(negedge clk);
    tx_req = '0;
    chk("to_done", 32'(tx_done), 32'h2);
    chk("to_tmo", 32'(tx_timeout), 32'd1);
    @(negedge clk);
    chk("to_tmo0", 32'(tx_timeout), 32'd0);
    chk("to_busy0", 32'(tx_busy), 32'd0);
    // cmd_done on the last wait cycle beats the timeout
    tx_req = 4'b0010;
    @(negedge clk);
    chk("race_grant", 32'(tx_grant), 32'h2);
    @(negedge clk);
    chk("race_send", 32'(cmd_send), 32'd1);
    repeat (15) @(negedge clk);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    tx_req = '0;
    chk("race_done", 32'(tx_done), 32'h2);
    chk("race_tmo", 32'(tx_timeout), 32'd0);
    @(negedge clk);
    // async reset mid-wait
    tx_req = 4'b0010;
    repeat (4) @(negedge clk);
    chk("ar_busy", 32'(tx_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_async", 32'({tx_grant, tx_sel, tx_busy, tx_done, tx_timeout, cmd_send}), 32'd0);
    @(negedge clk);
    chk("ar_nodone", 32'(tx_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ar_regrant", 32'(tx_grant), 32'h2);
    tx_req = '0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    chk("ar_finish", 32'(tx_done), 32'h2);
    @(negedge clk);
    // rx dispatch
    cmd_ready = 1'b1;
    rx_dest = 2'd3;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("rx_d3", 32'(rx_ready), 32'h8);
    chk("rx_nodrop", 32'(rx_drop), 32'd0);
    chk("rx3_drop", 32'(rx_drop3), 32'd1);
    chk("rx3_ready", 32'(rx_ready3), 32'd0);
    @(negedge clk);
    chk("rx_clear", 32'({rx_ready, rx_drop, rx_ready3, rx_drop3}), 32'd0);
    cmd_ready = 1'b1;
    rx_dest = 2'd1;
    @(negedge clk);
    rx_dest = 2'd0;
    chk("rx_b2b1", 32'(rx_ready), 32'h2);
    chk("rx3_b2b1", 32'(rx_ready3), 32'h2);
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("rx_b2b0", 32'(rx_ready), 32'h1);
    @(negedge clk);
    chk("rx_idle", 32'(rx_ready), 32'd0);
    // rx pulse coincident with cmd_done during a send
    tx_req = 4'b0001;
    @(negedge clk);
    chk("cc_grant", 32'(tx_grant), 32'h1);
    repeat (3) @(negedge clk);
    cmd_done = 1'b1;
    cmd_ready = 1'b1;
    rx_dest = 2'd2;
    @(negedge clk);
    cmd_done = 1'b0;
    cmd_ready = 1'b0;
    tx_req = '0;
    chk("cc_rx", 32'(rx_ready), 32'h4);
    chk("cc_done", 32'(tx_done), 32'h1);
    @(negedge clk);
    chk("cc_end", 32'({tx_busy, rx_ready}), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
